// File: rtl/serial_comp_pkg.sv
// Shared types and constants for the bit-serial 8-bit magnitude comparator.
// The optional pushbutton debouncer is selected with SERIAL_COMP_DEBOUNCE_EN.
package serial_comp_pkg;

   localparam int OPW  = 8;
   localparam int NIBW = 4;
   localparam int CNTW = $clog2(OPW);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {RES_EQ, RES_LT, RES_GT} res_t;

   // Maps the internal result onto the one-hot {l, g, e} LED pattern.
   function automatic logic [2:0] res_to_lge(input res_t r);
      case (r)
         RES_LT:  return 3'b100;
         RES_GT:  return 3'b010;
         default: return 3'b001;
      endcase
   endfunction

endpackage

// File: rtl/pb_conditioner.sv
// Pushbutton conditioner: synchronizer, optional debouncer (SERIAL_COMP_DEBOUNCE_EN)
// and rising-edge detect producing a single-cycle pulse per press.
module pb_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_COUNT    = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb,
   output logic pulse
);

   if (SYNC_STAGES < 2 || DB_COUNT < 1) begin : g_param_check
      $error("pb_conditioner: SYNC_STAGES must be >= 2 and DB_COUNT >= 1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   cond_level;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], pb};
   end

`ifdef SERIAL_COMP_DEBOUNCE_EN
   localparam int DBW = $clog2(DB_COUNT + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_COUNT - 1);

   logic [DBW-1:0] db_cnt;
   logic           db_level;

   // The counter only runs while the raw level disagrees with the accepted one,
   // so any bounce back to the accepted level restarts the stability window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         db_cnt   <= '0;
         db_level <= 1'b0;
      end else if (sync_q[SYNC_STAGES-1] == db_level) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         db_cnt   <= '0;
         db_level <= sync_q[SYNC_STAGES-1];
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   assign cond_level = db_level;
`else
   assign cond_level = sync_q[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= cond_level;
   end

   assign pulse = cond_level & ~prev_q;

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial 8-bit magnitude comparator: nibble-loaded operands, LSB-first compare,
// registered one-hot l/g/e result. Optional debouncer via SERIAL_COMP_DEBOUNCE_EN.
module serial_mag_comp
   import serial_comp_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DB_COUNT    = 50000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NIBW-1:0] inp,
   input  logic            pb1,
   input  logic            pb2,
   input  logic            pb3,
   input  logic            pb4,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            l,
   output logic            g,
   output logic            e
);

   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(OPW - 1);

   logic [3:0]     load;
   logic [OPW-1:0] a_q, b_q;
   logic [OPW-1:0] snap_a, snap_b;
   logic [CNTW-1:0] cnt;
   res_t           res, res_next;
   state_t         state;

   pb_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DB_COUNT(DB_COUNT)) u_pb1
      (.clk(clk), .rst_n(rst_n), .pb(pb1), .pulse(load[0]));
   pb_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DB_COUNT(DB_COUNT)) u_pb2
      (.clk(clk), .rst_n(rst_n), .pb(pb2), .pulse(load[1]));
   pb_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DB_COUNT(DB_COUNT)) u_pb3
      (.clk(clk), .rst_n(rst_n), .pb(pb3), .pulse(load[2]));
   pb_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DB_COUNT(DB_COUNT)) u_pb4
      (.clk(clk), .rst_n(rst_n), .pb(pb4), .pulse(load[3]));

   // Operand loads are independent of the FSM; the compare works on snapshots.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         if (load[0]) a_q[NIBW-1:0]   <= inp;
         if (load[1]) a_q[OPW-1:NIBW] <= inp;
         if (load[2]) b_q[NIBW-1:0]   <= inp;
         if (load[3]) b_q[OPW-1:NIBW] <= inp;
      end
   end

   // Later differing bits are more significant, so each difference overrides.
   always_comb begin
      res_next = res;
      if (snap_a[0] != snap_b[0]) res_next = snap_a[0] ? RES_GT : RES_LT;
   end

   // Handshake: start is a one-cycle request honoured only in IDLE; busy is high
   // for the 8 RUN cycles; done pulses once as l/g/e take the new result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         snap_a <= '0;
         snap_b <= '0;
         cnt    <= '0;
         res    <= RES_EQ;
         busy   <= 1'b0;
         done   <= 1'b0;
         l      <= 1'b0;
         g      <= 1'b0;
         e      <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  snap_a <= a_q;
                  snap_b <= b_q;
                  cnt    <= '0;
                  res    <= RES_EQ;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               snap_a <= snap_a >> 1;
               snap_b <= snap_b >> 1;
               cnt    <= cnt + 1'b1;
               res    <= res_next;
               if (cnt == CNT_LAST) begin
                  {l, g, e} <= res_to_lge(res_next);
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
